// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the serializer and sequence detector.
package seq_det_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel words in over valid/ready, one bit per clock out, gapless via a one-word holding buffer.
module bit_stream_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt, r_hbuf, w_hbuf_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_hvalid, w_hvalid_nxt;
  logic             w_accept, w_last, w_load;

  assign din_ready = !reset && !r_hvalid;
  assign w_accept  = din_valid && din_ready;
  assign w_last    = r_cnt == LAST;
  // hvalid blocks ready, so a load never coincides with an accept
  assign w_load    = r_hvalid && (r_state == IDLE || w_last);

  assign x_valid   = r_state == SHIFT;
  assign word_done = x_valid && w_last;
  assign x         = x_valid ? (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]) : IDLE_BIT;

  always_comb begin
    w_state_nxt  = r_state;
    w_sreg_nxt   = r_sreg;
    w_cnt_nxt    = r_cnt;
    w_hbuf_nxt   = w_accept ? din : r_hbuf;
    w_hvalid_nxt = w_accept || (r_hvalid && !w_load);
    if (w_load) begin
      w_sreg_nxt  = r_hbuf;
      w_cnt_nxt   = '0;
      w_state_nxt = SHIFT;
    end else if (r_state == SHIFT) begin
      w_sreg_nxt  = w_last ? r_sreg : (MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]});
      w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
      w_state_nxt = w_last ? IDLE : SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_hbuf   <= '0;
      r_hvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hbuf   <= w_hbuf_nxt;
      r_hvalid <= w_hvalid_nxt;
    end
  end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: directed checks of an MSB-first and an LSB-first 4-bit serializer.
module tb_bit_stream_serializer;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din [2];
  logic       vld [2];
  logic       rdy [2];
  logic       xo  [2];
  logic       xv  [2];
  logic       wd  [2];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] win;
  logic [7:0] stream;

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
    .x(xo[0]), .x_valid(xv[0]), .word_done(wd[0])
  );

  bit_stream_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
    .x(xo[1]), .x_valid(xv[1]), .word_done(wd[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic single_word(input int s, input logic [3:0] w, input logic [3:0] e);
    din[s] = w;
    vld[s] = 1'b1;
    tick;
    check("acc_rdy", 32'(rdy[s]), 0);
    check("lat_xv", 32'(xv[s]), 0);
    vld[s] = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("sw_x", 32'(xo[s]), 32'(e[3-i]));
      check("sw_xv", 32'(xv[s]), 1);
      check("sw_wd", 32'(wd[s]), 32'(i == 3));
      tick;
    end
    check("sw_end_xv", 32'(xv[s]), 0);
    check("sw_end_x", 32'(xo[s]), 0);
  endtask

  initial begin
    din[0] = '0; din[1] = '0; vld[0] = 1'b0; vld[1] = 1'b0;
    tick;
    tick;
    check("rst_rdy", 32'(rdy[0]), 0);
    check("rst_xv", 32'(xv[0]), 0);
    check("rst_x", 32'(xo[0]), 0);
    check("rst_wd", 32'(wd[0]), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle_x", 32'(xo[0]), 0);
      check("idle_xv", 32'(xv[0]), 0);
      check("idle_wd", 32'(wd[0]), 0);
      check("idle_rdy", 32'(rdy[0]), 1);
    end

    single_word(0, PATTERN, 4'b1011);
    single_word(1, 4'b1101, 4'b1011);

    stream = 8'b1011_0110;
    win = '0;
    din[0] = 4'b1011;
    vld[0] = 1'b1;
    tick;
    check("b2b_rdy_held", 32'(rdy[0]), 0);
    din[0] = 4'b0110;
    tick;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 4) check("b2b_rdy_free", 32'(rdy[0]), 1);
      if (i == 1) begin
        check("b2b_rdy_busy", 32'(rdy[0]), 0);
        vld[0] = 1'b0;
      end
      check("b2b_x", 32'(xo[0]), 32'(stream[7-i]));
      check("b2b_xv", 32'(xv[0]), 1);
      check("b2b_wd", 32'(wd[0]), 32'(i == 3 || i == 7));
      win = {win[2:0], xo[0]};
      check("b2b_det", 32'(i >= 3 && win == PATTERN), 32'(i == 3 || i == 6));
      tick;
    end
    check("b2b_end_xv", 32'(xv[0]), 0);

    din[0] = 4'b1011;
    vld[0] = 1'b1;
    tick;
    din[0] = 4'b0110;
    tick;
    check("mid_b1", 32'(xo[0]), 1);
    tick;
    check("mid_b2", 32'(xo[0]), 0);
    check("mid_held", 32'(rdy[0]), 0);
    reset = 1'b1;
    #1;
    check("mid_rdy_rst", 32'(rdy[0]), 0);
    tick;
    check("mid_xv", 32'(xv[0]), 0);
    check("mid_x", 32'(xo[0]), 0);
    check("mid_wd", 32'(wd[0]), 0);
    reset = 1'b0;
    vld[0] = 1'b0;
    #1;
    check("mid_rdy_rel", 32'(rdy[0]), 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("mid_quiet", 32'(xv[0]), 0);
    end

    single_word(0, 4'b1001, 4'b1001);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_xv", 32'(xv[0]), 0);
      check("stall_x", 32'(xo[0]), 0);
      check("stall_rdy", 32'(rdy[0]), 1);
    end
    single_word(0, 4'b0101, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
